yc_sep_sequencer: RTL
=====================

YC_SEP_SEQUENCER -- requirements
Module: yc_sep_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: composite/luma/chroma sample width, signed.
REQ-002 SHALL have parameter WINDOW_SIZE, default 32: Y/C separator averaging window in samples.
REQ-003 SHALL have parameter SEP_LAT, default 17: separator input-to-output latency in clocks.
REQ-004 SHALL have parameter SYNC_MIN, default 64: consecutive below-threshold samples that declare a sync tip.
REQ-005 SHALL have parameter MAX_LINE, default 2047: watchdog limit in samples since line_start.
REQ-006 SHALL have port clk, input, 1: the only clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port data_in, input, DATA_WIDTH signed: composite sample, one per clock, the same stream that feeds the separator.
REQ-009 SHALL have ports luma_in and chroma_in, each input, DATA_WIDTH signed: separator outputs.
REQ-010 SHALL have port sync_thresh, input, DATA_WIDTH signed: sync-tip level.
REQ-011 SHALL have port porch_len, input, 10: back-porch length in samples.
REQ-012 SHALL have port active_len, input, 11: active-video samples per line.
REQ-013 SHALL have ports luma_out and chroma_out, each output, DATA_WIDTH signed: qualified separator samples.
REQ-014 SHALL have port out_valid, output, 1: luma_out and chroma_out are active video.
REQ-015 SHALL have port line_start, output, 1: one-cycle pulse at the sync trailing edge.
REQ-016 SHALL have port line_trunc, output, 1: one-cycle pulse when a sync arrives during ACTIVE.
REQ-017 SHALL have port sync_lost, output, 1: one-cycle pulse when the watchdog fires.

Function
REQ-018 SHALL implement states SEARCH, SYNC_TIP, PORCH, FILL and ACTIVE.
REQ-019 SHALL keep a run counter of consecutive samples with data_in < sync_thresh (signed compare), clear it on any sample >= sync_thresh, and saturate it at SYNC_MIN.
REQ-020 SHALL go SEARCH->SYNC_TIP in the cycle the run counter reaches SYNC_MIN.
REQ-021 SHALL go SYNC_TIP->PORCH on the first sample >= sync_thresh, pulse line_start in the following cycle, clear the sample counter, and latch porch_len and active_len.
REQ-022 SHALL go PORCH->FILL after the latched porch_len samples; porch_len=0 SHALL skip directly to FILL.
REQ-023 SHALL go FILL->ACTIVE after WINDOW_SIZE+SEP_LAT samples, so that no pre-porch sample contributes to any qualified output.
REQ-024 SHALL go ACTIVE->SEARCH after the latched active_len samples; active_len=0 SHALL go straight to SEARCH with no out_valid.
REQ-025 SHALL register outputs: luma_out<=luma_in, chroma_out<=chroma_in, out_valid<=(state==ACTIVE); latency is 1 clock, and out_valid is never asserted outside ACTIVE+1.
REQ-026 SHALL go ACTIVE->SYNC_TIP when the run counter reaches SYNC_MIN during ACTIVE, pulse line_trunc, and drop out_valid on the next cycle.
REQ-027 SHALL increment a line-length counter every sample from line_start, saturating.
REQ-028 SHALL, when the line-length counter exceeds MAX_LINE in any state other than SEARCH, pulse sync_lost, enter SEARCH, and clear all counters.
REQ-029 SHALL give REQ-028 priority when REQ-026 and REQ-028 occur in the same cycle.
REQ-030 SHALL ignore config input changes outside the latch cycle (REQ-021).

Reset
REQ-031 SHALL, while rst_n=0 at a clk edge, set state=SEARCH, zero all counters, and set luma_out=0, chroma_out=0, out_valid=0, line_start=0, line_trunc=0 and sync_lost=0.
REQ-032 SHALL, after a mid-line reset, emit no out_valid until a full SYNC_MIN sync run and a complete PORCH/FILL sequence have occurred.

Structure
REQ-033 SHALL place the state enum, DATA_WIDTH and WINDOW_SIZE defaults, and SYNC_MIN in shared package yc_pkg.
REQ-034 SHALL implement the REQ-019 run counter and compare as sub-module sync_run_detector.

Verification
REQ-035 SHALL cover: 64 samples of -1500, then 0, with sync_thresh=-1000, porch_len=20, active_len=100 -> line_start 1 cycle after the edge; out_valid rises 20+32+17+1 cycles after line_start, stays high exactly 100 cycles, and luma_out equals luma_in delayed 1.
REQ-036 SHALL cover: a 63-sample sync run -> no SYNC_TIP, no line_start.
REQ-037 SHALL cover: a 64-sample sync 50 samples into ACTIVE -> line_trunc pulse, out_valid low next cycle, new line_start at the sync edge.
REQ-038 SHALL cover: no sync for 2048 samples after line_start -> sync_lost pulse, state SEARCH, out_valid=0.
REQ-039 SHALL cover: rst_n=0 for 1 cycle mid-ACTIVE -> all outputs 0 next cycle; out_valid stays 0 until the next full sync and fill.
REQ-040 SHALL cover: porch_len=0 and active_len=0 -> FILL entered directly after sync, zero out_valid cycles, return to SEARCH.

Source files
------------

// File: rtl/yc_pkg.sv
// Shared types and defaults for the Y/C separator line sequencer.
// The state encoding is visible to anything that needs to observe the sequencer.
package yc_pkg;

  typedef enum logic [2:0] {
    SEARCH   = 3'd0,
    SYNC_TIP = 3'd1,
    PORCH    = 3'd2,
    FILL     = 3'd3,
    ACTIVE   = 3'd4
  } yc_state_t;

  localparam int YC_DATA_WIDTH  = 12;
  localparam int YC_WINDOW_SIZE = 32;
  localparam int YC_SYNC_MIN    = 64;
  localparam int YC_PORCH_W     = 10;
  localparam int YC_ACTIVE_W    = 11;

endpackage

// File: rtl/sync_run_detector.sv
// Counts consecutive composite samples below the sync-tip level, saturating at SYNC_MIN.
// hit is combinational so the sequencer can act in the cycle the run completes.
module sync_run_detector
  import yc_pkg::*;
#(
  parameter int DATA_WIDTH = YC_DATA_WIDTH,
  parameter int SYNC_MIN   = YC_SYNC_MIN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic signed [DATA_WIDTH-1:0] sync_thresh,
  output logic                         below,
  output logic                         hit
);

  localparam int               RUN_W   = $clog2(SYNC_MIN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SYNC_MIN);

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;

  function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + 1'b1;
  endfunction

  always_comb begin
    below   = (data_in < sync_thresh);
    run_nxt = below ? sat_run(run_cnt) : '0;
    hit     = (run_nxt == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_nxt;
    end
  end

endmodule

// File: rtl/yc_sep_sequencer.sv
// Line sequencer for a Y/C separator: finds sync tips, skips porch and filter fill,
// then qualifies luma/chroma as active video for a programmed number of samples.
module yc_sep_sequencer
  import yc_pkg::*;
#(
  parameter int DATA_WIDTH  = YC_DATA_WIDTH,
  parameter int WINDOW_SIZE = YC_WINDOW_SIZE,
  parameter int SEP_LAT     = 17,
  parameter int SYNC_MIN    = YC_SYNC_MIN,
  parameter int MAX_LINE    = 2047
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic signed [DATA_WIDTH-1:0] luma_in,
  input  logic signed [DATA_WIDTH-1:0] chroma_in,
  input  logic signed [DATA_WIDTH-1:0] sync_thresh,
  input  logic [9:0]                   porch_len,
  input  logic [10:0]                  active_len,
  output logic signed [DATA_WIDTH-1:0] luma_out,
  output logic signed [DATA_WIDTH-1:0] chroma_out,
  output logic                         out_valid,
  output logic                         line_start,
  output logic                         line_trunc,
  output logic                         sync_lost
);

  // The fill wait covers the whole averaging window plus separator latency, so
  // nothing sampled before the porch ended can reach a qualified output.
  localparam int FILL_LEN = WINDOW_SIZE + SEP_LAT;
  localparam int FILL_W   = $clog2(FILL_LEN + 1);
  localparam int CNT_W    = (FILL_W > YC_ACTIVE_W) ? FILL_W : YC_ACTIVE_W;
  localparam int LINE_W   = $clog2(MAX_LINE + 2);

  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(FILL_LEN - 1);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(MAX_LINE);
  localparam logic [LINE_W-1:0] LINE_SAT  = LINE_W'(MAX_LINE + 1);

  yc_state_t state;
  yc_state_t state_nxt;

  logic [CNT_W-1:0]       samp_cnt;
  logic [LINE_W-1:0]      line_cnt;
  logic [YC_PORCH_W-1:0]  porch_q;
  logic [YC_ACTIVE_W-1:0] active_q;
  logic [CNT_W-1:0]       porch_last;
  logic [CNT_W-1:0]       active_last;

  logic below;
  logic hit;
  logic wdog;
  logic line_edge;

  logic ls_nxt;
  logic lt_nxt;
  logic sl_nxt;
  logic vld_nxt;

  logic signed [DATA_WIDTH-1:0] luma_p1;
  logic signed [DATA_WIDTH-1:0] chroma_p1;
  logic                         vld_p1;
  logic                         ls_p1;
  logic                         lt_p1;
  logic                         sl_p1;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [LINE_W-1:0] sat_line(input logic [LINE_W-1:0] v);
    return (v >= LINE_SAT) ? LINE_SAT : v + 1'b1;
  endfunction

  sync_run_detector #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_MIN   (SYNC_MIN)
  ) u_run (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (wdog),
    .data_in     (data_in),
    .sync_thresh (sync_thresh),
    .below       (below),
    .hit         (hit)
  );

  assign porch_last  = CNT_W'(porch_q) - 1'b1;
  assign active_last = CNT_W'(active_q) - 1'b1;
  assign wdog        = (state != SEARCH) && (line_cnt > LINE_MAX);
  assign line_edge   = (state == SYNC_TIP) && !below;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // The watchdog overrides every other transition, including a truncating sync.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SEARCH: begin
        if (hit) state_nxt = SYNC_TIP;
      end
      SYNC_TIP: begin
        if (!below) state_nxt = (porch_len == '0) ? FILL : PORCH;
      end
      PORCH: begin
        if (samp_cnt == porch_last) state_nxt = FILL;
      end
      FILL: begin
        if (samp_cnt == FILL_LAST) state_nxt = (active_q == '0) ? SEARCH : ACTIVE;
      end
      ACTIVE: begin
        if (hit) begin
          state_nxt = SYNC_TIP;
        end else if (samp_cnt == active_last) begin
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
    if (wdog) state_nxt = SEARCH;
  end

  always_comb begin
    ls_nxt  = line_edge && !wdog;
    lt_nxt  = (state == ACTIVE) && hit && !wdog;
    sl_nxt  = wdog;
    vld_nxt = (state == ACTIVE) && !wdog;
  end

  // Sample counter restarts on every state change; line counter runs from the sync edge.
  always_ff @(posedge clk) begin
    if (!rst_n || wdog) begin
      samp_cnt <= '0;
      line_cnt <= '0;
    end else begin
      samp_cnt <= (state_nxt != state) ? '0 : sat_cnt(samp_cnt);
      if ((state == SEARCH) || line_edge) begin
        line_cnt <= '0;
      end else begin
        line_cnt <= sat_line(line_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      porch_q  <= '0;
      active_q <= '0;
    end else if (line_edge && !wdog) begin
      porch_q  <= porch_len;
      active_q <= active_len;
    end
  end

  // Stage p1: registered outputs, one clock behind the separator samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      luma_p1   <= '0;
      chroma_p1 <= '0;
      vld_p1    <= 1'b0;
      ls_p1     <= 1'b0;
      lt_p1     <= 1'b0;
      sl_p1     <= 1'b0;
    end else begin
      luma_p1   <= luma_in;
      chroma_p1 <= chroma_in;
      vld_p1    <= vld_nxt;
      ls_p1     <= ls_nxt;
      lt_p1     <= lt_nxt;
      sl_p1     <= sl_nxt;
    end
  end

  assign luma_out   = luma_p1;
  assign chroma_out = chroma_p1;
  assign out_valid  = vld_p1;
  assign line_start = ls_p1;
  assign line_trunc = lt_p1;
  assign sync_lost  = sl_p1;

endmodule
